// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operation encodings, FSM state
// type and small operation-decode helpers.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit 0 of the encoding marks unsigned operations, bit 1 marks remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes divide-by-zero and signed overflow without iterating.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [1:0]           OP,
  input  logic [WIDTH-1:0]     OPERAND_A,
  input  logic [WIDTH-1:0]     OPERAND_B,
  input  logic [ADD_WIDTH-1:0] DEST_ADDRESS,
  input  logic                 FLUSH,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [WIDTH-1:0]     RESULT,
  output logic [ADD_WIDTH-1:0] RESULT_ADDRESS
);

  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       rem_q;
  logic [WIDTH-1:0]       quo_q;
  logic [WIDTH-1:0]       dvs_q;
  logic                   rem_sel_q;
  logic                   a_neg_q;
  logic                   q_neg_q;
  logic                   dbz_q;
  logic [ADD_WIDTH-1:0]   addr_q;

  // Operand decode at the START edge: magnitudes and sign flags.
  logic                   signed_in;
  logic                   rem_in;
  logic                   a_neg_in;
  logic                   b_neg_in;
  logic                   dbz_in;
  logic [WIDTH-1:0]       a_mag_in;
  logic [WIDTH-1:0]       b_mag_in;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    signed_in = op_is_signed(OP);
    rem_in    = op_is_rem(OP);
    a_neg_in  = signed_in & OPERAND_A[WIDTH-1];
    b_neg_in  = signed_in & OPERAND_B[WIDTH-1];
    dbz_in    = (OPERAND_B == '0);
    a_mag_in  = a_neg_in ? -OPERAND_A : OPERAND_A;
    b_mag_in  = b_neg_in ? -OPERAND_B : OPERAND_B;
  end

`ifdef DIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             ovf_in;
  logic             special_in;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    ovf_in      = signed_in && (OPERAND_A == MIN_NEG) && (OPERAND_B == ALL_ONES);
    special_in  = dbz_in | ovf_in;
    special_res = '0;
    if (dbz_in)
      special_res = rem_in ? OPERAND_A : ALL_ONES;
    else if (ovf_in)
      special_res = rem_in ? '0 : MIN_NEG;
  end
`endif

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits. The extra top bit of trial is the borrow.
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    take  = ~trial[WIDTH];
    quo_n = {quo_q[WIDTH-2:0], take};
    rem_n = take ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  end

  // Sign fix-up of the final step's outputs. Divide-by-zero forces the
  // quotient to all-ones; its remainder is |A| re-signed, i.e. A itself.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    q_fix     = dbz_q ? ALL_ONES : (q_neg_q ? -quo_n : quo_n);
    r_fix     = a_neg_q ? -rem_n : rem_n;
    final_res = rem_sel_q ? r_fix : q_fix;
  end

  // NOTE: all state, including the datapath registers, uses non-blocking
  // assignments and is cleared by the asynchronous reset so no X leaks out.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= div_pkg::IDLE;
      cnt            <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      rem_sel_q      <= 1'b0;
      a_neg_q        <= 1'b0;
      q_neg_q        <= 1'b0;
      dbz_q          <= 1'b0;
      addr_q         <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      RESULT         <= '0;
      RESULT_ADDRESS <= '0;
    end else begin
      case (state)
        div_pkg::IDLE: begin
          if (START && !FLUSH) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag_in;
            dvs_q     <= b_mag_in;
            rem_sel_q <= rem_in;
            a_neg_q   <= a_neg_in;
            q_neg_q   <= a_neg_in ^ b_neg_in;
            dbz_q     <= dbz_in;
            addr_q    <= DEST_ADDRESS;
            BUSY      <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (special_in) begin
              state          <= div_pkg::DONE;
              DONE           <= 1'b1;
              RESULT         <= special_res;
              RESULT_ADDRESS <= DEST_ADDRESS;
            end else begin
              state <= div_pkg::CALC;
            end
`else
            state <= div_pkg::CALC;
`endif
          end
        end

        div_pkg::CALC: begin
          if (FLUSH) begin
            state <= div_pkg::IDLE;
            BUSY  <= 1'b0;
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              state          <= div_pkg::DONE;
              DONE           <= 1'b1;
              RESULT         <= final_res;
              RESULT_ADDRESS <= addr_q;
            end
          end
        end

        div_pkg::DONE: begin
          state          <= div_pkg::IDLE;
          BUSY           <= 1'b0;
          DONE           <= 1'b0;
          RESULT         <= '0;
          RESULT_ADDRESS <= '0;
        end

        default: begin
          state          <= div_pkg::IDLE;
          BUSY           <= 1'b0;
          DONE           <= 1'b0;
          RESULT         <= '0;
          RESULT_ADDRESS <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_div_unit;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] OPERAND_A;
  logic [WIDTH-1:0] OPERAND_B;
  logic [AW-1:0]    DEST_ADDRESS;
  logic             FLUSH;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic [AW-1:0]    RESULT_ADDRESS;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(WIDTH), .ADD_WIDTH(AW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .START          (START),
    .OP             (OP),
    .OPERAND_A      (OPERAND_A),
    .OPERAND_B      (OPERAND_B),
    .DEST_ADDRESS   (DEST_ADDRESS),
    .FLUSH          (FLUSH),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .RESULT         (RESULT),
    .RESULT_ADDRESS (RESULT_ADDRESS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V style division semantics using plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit sgn = (op == DIV) || (op == REM);
    bit rem = (op == REM) || (op == REMU);
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      int sa = a;
      int sb = b;
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  // Cycles from the START cycle (counted as 1) to the cycle in which DONE is high.
  function automatic int ref_cycles(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    bit sgn = (op == DIV) || (op == REM);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return WIDTH + 1;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one request, returns just after the edge that samples it, then scrambles the inputs.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [AW-1:0] addr);
    START        = 1'b1;
    OP           = op;
    OPERAND_A    = a;
    OPERAND_B    = b;
    DEST_ADDRESS = addr;
    tick();
    START        = 1'b0;
    OP           = 2'($urandom);
    OPERAND_A    = $urandom;
    OPERAND_B    = $urandom;
    DEST_ADDRESS = AW'($urandom);
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 60) begin
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (DONE) dones++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [AW-1:0] addr,
                        input logic [31:0] exp);
    int cyc;
    bit seen;
    start_op(op, a, b, addr);
    check({tag, "_busy"}, BUSY, 1'b1);
    if (!DONE) check({tag, "_result_zero_in_calc"}, RESULT, 32'h0);
    wait_done(cyc, seen);
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, cyc, ref_cycles(op, a, b));
    check({tag, "_result"}, RESULT, exp);
    check({tag, "_addr"}, RESULT_ADDRESS, addr);
    tick();
    check({tag, "_after"}, {BUSY, DONE, RESULT, RESULT_ADDRESS}, '0);
  endtask

  initial begin
    int cyc;
    int dones;
    bit seen;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    RESET        = 1'b0;
    START        = 1'b0;
    FLUSH        = 1'b0;
    OP           = 2'b00;
    OPERAND_A    = '0;
    OPERAND_B    = '0;
    DEST_ADDRESS = '0;
    #12;
    check("reset_outputs", {BUSY, DONE, RESULT, RESULT_ADDRESS}, '0);
    tick();
    RESET = 1'b1;
    tick();

    run_op("divu_100_7",  DIVU, 32'd100,        32'd7,          5'd5,  32'd14);
    run_op("rem_m7_2",    REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF);
    run_op("div_m7_2",    DIV,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD);
    run_op("div_ovf",     DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000);
    run_op("rem_ovf",     REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h0);
    run_op("divu_5_0",    DIVU, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF);
    run_op("remu_5_0",    REMU, 32'd5,          32'd0,          5'd9,  32'd5);
    run_op("div_m5_0",    DIV,  32'hFFFF_FFFB,  32'd0,          5'd10, 32'hFFFF_FFFF);
    run_op("rem_m5_0",    REM,  32'hFFFF_FFFB,  32'd0,          5'd11, 32'hFFFF_FFFB);
    run_op("divu_dest0",  DIVU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'hFFFF_FFFF);

    // START during CALC is ignored; the original operation completes.
    start_op(DIVU, 32'd1000, 32'd10, 5'd9);
    repeat (5) tick();
    START = 1'b1; OP = REMU; OPERAND_A = 32'd77; OPERAND_B = 32'd5; DEST_ADDRESS = 5'd2;
    tick();
    START = 1'b0;
    wait_done(cyc, seen);
    check("busy_start_seen", seen, 1'b1);
    check("busy_start_latency", cyc + 6, WIDTH + 1);
    check("busy_start_result", RESULT, 32'd100);
    check("busy_start_addr", RESULT_ADDRESS, 5'd9);
    count_dones(4, dones);
    check("busy_start_no_second", {BUSY, 6'(dones)}, 7'd0);

    // FLUSH in the tenth CALC cycle aborts with no DONE.
    start_op(DIVU, 32'd12345, 32'd11, 5'd12);
    repeat (9) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush_idle", {BUSY, DONE}, 2'b00);
    count_dones(40, dones);
    check("flush_no_done", dones, 0);
    run_op("after_flush", DIVU, 32'd12345, 32'd11, 5'd12, 32'd1122);

    // START together with FLUSH in IDLE does not start anything.
    START = 1'b1; FLUSH = 1'b1; OP = DIVU; OPERAND_A = 32'd9; OPERAND_B = 32'd3;
    tick();
    START = 1'b0; FLUSH = 1'b0;
    check("start_flush_idle", BUSY, 1'b0);
    count_dones(40, dones);
    check("start_flush_no_done", dones, 0);

    // Asynchronous reset in the fifteenth CALC cycle.
    start_op(DIV, 32'hFFFF_0000, 32'd3, 5'd21);
    repeat (14) tick();
    #2 RESET = 1'b0;
    #1 check("reset_mid_outputs", {BUSY, DONE, RESULT, RESULT_ADDRESS}, '0);
    tick();
    RESET = 1'b1;
    count_dones(40, dones);
    check("reset_mid_no_done", {BUSY, 6'(dones)}, 7'd0);

    // Randomized back-to-back operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       a = 32'h0;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 16);
        3:       b = 32'h1;
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, AW'($urandom), ref_result(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
